// File: rtl/game_pkg.sv
// Shared constants, FSM state type and combo multiplier for the rhythm-game
// scoring path.
package game_pkg;
  localparam int NUM_LANES   = 5;
  localparam int BASE_POINTS = 10;
  localparam int SCORE_MAX   = 99999;
  localparam int COMBO_MAX   = 99;
  localparam int SCORE_W     = 17;
  localparam int COMBO_W     = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_JUDGE,
    S_DONE
  } judge_state_t;

  // Multiplier steps every 8 consecutive hits, capped at x4.
  function automatic logic [2:0] combo_mult(input logic [COMBO_W-1:0] combo);
    logic [2:0] m;
    if (combo >= 7'd24)      m = 3'd4;
    else if (combo >= 7'd16) m = 3'd3;
    else if (combo >= 7'd8)  m = 3'd2;
    else                     m = 3'd1;
    return m;
  endfunction
endpackage

// File: rtl/lane_press_detect.sv
// One lane's button capture: 2-flop synchronizer, rising-edge detect and a
// sticky pending bit that survives until the judge FSM clears it.
module lane_press_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  input  logic clr_i,
  output logic pending_o
);
  logic sync1_q, sync2_q, prev_q, pending_q;
  logic rise_w, pending_d;

  assign rise_w    = sync2_q & ~prev_q;
  // A press landing on the clear cycle belongs to the next frame, so set wins.
  assign pending_d = (pending_q & ~clr_i) | rise_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;
endmodule

// File: rtl/hit_scorer.sv
// Per-frame hit/miss judge: snapshots pending presses at frame_tick, walks the
// lanes one per cycle, and maintains saturating score, combo and miss flash.
module hit_scorer #(
  parameter int NUM_LANES   = game_pkg::NUM_LANES,
  parameter int BASE_POINTS = game_pkg::BASE_POINTS,
  parameter int SCORE_MAX   = game_pkg::SCORE_MAX,
  parameter int COMBO_MAX   = game_pkg::COMBO_MAX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic [NUM_LANES-1:0] button,
  input  logic [NUM_LANES-1:0] note_in_zone,
  input  logic [NUM_LANES-1:0] note_passed,
  output logic [NUM_LANES-1:0] note_clear,
  output logic [16:0]          score,
  output logic [6:0]           combo,
  output logic                 miss_flash
);
  import game_pkg::*;

  localparam int LIDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  judge_state_t         state_q, state_d;
  logic [NUM_LANES-1:0] pending;
  logic                 pend_clr;
  logic [NUM_LANES-1:0] snap_q, snap_d, zone_q, zone_d;
  logic [NUM_LANES-1:0] clear_q, clear_d;
  logic [LIDX_W-1:0]    lane_q, lane_d;
  logic [16:0]          score_q, score_d;
  logic [6:0]           combo_q, combo_d;
  logic                 miss_q, miss_d;
  logic                 flash_q, flash_d;
  logic [17:0]          sum_w;
  logic                 passed_w;

  assign pend_clr = (state_q == S_IDLE) && frame_tick;
  assign passed_w = |note_passed;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_press_detect u_det (
      .clk      (clk),
      .reset    (reset),
      .btn_i    (button[g]),
      .clr_i    (pend_clr),
      .pending_o(pending[g])
    );
  end

  // Widen before the compare so the saturation check sees the carry.
  assign sum_w = {1'b0, score_q} + 18'(BASE_POINTS * int'(combo_mult(combo_q)));

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    zone_d  = zone_q;
    lane_d  = lane_q;
    score_d = score_q;
    combo_d = combo_q;
    miss_d  = miss_q;
    flash_d = flash_q;
    clear_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          snap_d  = pending;
          zone_d  = note_in_zone;
          lane_d  = '0;
          state_d = S_JUDGE;
        end
      end
      S_JUDGE: begin
        if (snap_q[lane_q]) begin
          if (zone_q[lane_q]) begin
            score_d = (sum_w > 18'(SCORE_MAX)) ? 17'(SCORE_MAX) : sum_w[16:0];
            combo_d = (combo_q >= 7'(COMBO_MAX)) ? 7'(COMBO_MAX) : combo_q + 7'd1;
            clear_d[lane_q] = 1'b1;
          end else begin
            combo_d = '0;
            miss_d  = 1'b1;
          end
        end
        if (lane_q == LIDX_W'(NUM_LANES - 1)) state_d = S_DONE;
        else                                  lane_d  = lane_q + 1'b1;
      end
      S_DONE: begin
        flash_d = miss_q | passed_w;
        miss_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A passed note breaks the combo even on a hit cycle; the points stand.
    if (passed_w) begin
      combo_d = '0;
      if (state_q != S_DONE) miss_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      zone_q  <= '0;
      lane_q  <= '0;
      score_q <= '0;
      combo_q <= '0;
      miss_q  <= 1'b0;
      flash_q <= 1'b0;
      clear_q <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      zone_q  <= zone_d;
      lane_q  <= lane_d;
      score_q <= score_d;
      combo_q <= combo_d;
      miss_q  <= miss_d;
      flash_q <= flash_d;
      clear_q <= clear_d;
    end
  end

  assign note_clear = clear_q;
  assign score      = score_q;
  assign combo      = combo_q;
  assign miss_flash = flash_q;
endmodule

// File: tb/tb_hit_scorer.sv
// Directed bench for hit_scorer: a default instance and a SCORE_MAX=50
// instance share stimulus; a queue scoreboard holds per-frame expectations.
module tb_hit_scorer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [4:0] button = '0;
  logic [4:0] note_in_zone = '0;
  logic [4:0] note_passed = '0;
  logic [4:0] note_clear, s_note_clear;
  logic [16:0] score, s_score;
  logic [6:0]  combo, s_combo;
  logic        miss_flash, s_miss_flash;

  int ncomp = 0;
  int nfail = 0;

  typedef struct packed {
    logic [16:0] s0;
    logic [16:0] s1;
    logic [6:0]  cb;
    logic        fl;
  } res_t;

  res_t       exp_res[$];
  logic [4:0] exp_clr[$];

  int m_score0, m_score1, m_combo;
  logic m_miss, m_flash;

  hit_scorer u_dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .button(button),
    .note_in_zone(note_in_zone), .note_passed(note_passed),
    .note_clear(note_clear), .score(score), .combo(combo), .miss_flash(miss_flash)
  );

  hit_scorer #(.SCORE_MAX(50)) u_sat (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .button(button),
    .note_in_zone(note_in_zone), .note_passed(note_passed),
    .note_clear(s_note_clear), .score(s_score), .combo(s_combo), .miss_flash(s_miss_flash)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic int mult_of(input int c);
    if (c < 8)  return 1;
    if (c < 16) return 2;
    if (c < 24) return 3;
    return 4;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_score0 = 0; m_score1 = 0; m_combo = 0; m_miss = 1'b0; m_flash = 1'b0;
    exp_res.delete(); exp_clr.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_combo"}, combo, 0);
    chk({tag, "_clear"}, note_clear, 0);
    chk({tag, "_flash"}, miss_flash, 0);
    chk({tag, "_sat_score"}, s_score, 0);
    chk({tag, "_sat_flash"}, s_miss_flash, 0);
  endtask

  task automatic press(input logic [4:0] mask);
    @(negedge clk); button = mask;
    repeat (4) @(negedge clk);
    button = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_pass(input logic [4:0] mask);
    @(negedge clk); note_passed = mask;
    @(negedge clk); note_passed = '0;
    m_combo = 0; m_miss = 1'b1;
  endtask

  // pexp: lanes the bench expects to be judged; late: lanes whose edge lands
  // on the tick cycle; pass_at: JUDGE lane slot for a note_passed pulse.
  task automatic frame(input logic [4:0] pexp, input logic [4:0] zone,
                       input logic [4:0] late, input int pass_at,
                       input logic [4:0] pmask);
    res_t r;
    logic [4:0] c;
    @(negedge clk); button = button | late;
    @(negedge clk);
    chk("flash_hold", miss_flash, m_flash);
    @(negedge clk);
    note_in_zone = zone; frame_tick = 1'b1;
    for (int k = 0; k < 5; k++) begin
      c = '0;
      if (pexp[k]) begin
        if (zone[k]) begin
          c[k] = 1'b1;
          m_score0 = min_i(m_score0 + 10 * mult_of(m_combo), 99999);
          m_score1 = min_i(m_score1 + 10 * mult_of(m_combo), 50);
          m_combo  = min_i(m_combo + 1, 99);
        end else begin
          m_combo = 0; m_miss = 1'b1;
        end
      end
      if (k == pass_at) begin m_combo = 0; m_miss = 1'b1; end
      exp_clr.push_back(c);
    end
    m_flash = m_miss; m_miss = 1'b0;
    r.s0 = 17'(m_score0); r.s1 = 17'(m_score1); r.cb = 7'(m_combo); r.fl = m_flash;
    exp_res.push_back(r);
    @(negedge clk); frame_tick = 1'b0;
    for (int k = 0; k < 5; k++) begin
      note_passed = (k == pass_at) ? pmask : 5'd0;
      @(negedge clk);
      c = exp_clr.pop_front();
      chk("note_clear", note_clear, c);
      chk("sat_note_clear", s_note_clear, c);
    end
    note_passed = '0;
    @(negedge clk);
    r = exp_res.pop_front();
    chk("score", score, r.s0);
    chk("sat_score", s_score, r.s1);
    chk("combo", combo, r.cb);
    chk("sat_combo", s_combo, r.cb);
    chk("miss_flash", miss_flash, r.fl);
    button = button & ~late;
    note_in_zone = '0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic hits on lane 0; sat instance runs 10,20,30,...
    for (int i = 0; i < 3; i++) begin
      press(5'b00001);
      frame(5'b00001, 5'b00001, 5'b0, -1, 5'b0);
    end
    chk("basic_score", score, 30);
    chk("basic_combo", combo, 3);
    for (int i = 0; i < 3; i++) begin
      press(5'b00001);
      frame(5'b00001, 5'b00001, 5'b0, -1, 5'b0);
    end
    chk("sat_six_hits", s_score, 50);

    // Wrong press on lane 3 breaks the combo, then the flash clears.
    press(5'b01000);
    frame(5'b01000, 5'b00000, 5'b0, -1, 5'b0);
    chk("miss_combo", combo, 0);
    chk("miss_score", score, 60);
    frame(5'b0, 5'b0, 5'b0, -1, 5'b0);

    // note_passed while idle.
    press(5'b00001);
    frame(5'b00001, 5'b00001, 5'b0, -1, 5'b0);
    pulse_pass(5'b00100);
    frame(5'b0, 5'b0, 5'b0, -1, 5'b0);

    // Held button across 4 frames: judged once.
    @(negedge clk); button = 5'b00010;
    repeat (5) @(negedge clk);
    frame(5'b00010, 5'b00010, 5'b0, -1, 5'b0);
    for (int i = 0; i < 3; i++) frame(5'b0, 5'b00010, 5'b0, -1, 5'b0);
    @(negedge clk); button = '0;
    repeat (4) @(negedge clk);

    // Edge on the tick cycle is deferred one frame.
    frame(5'b0, 5'b00100, 5'b00100, -1, 5'b0);
    frame(5'b00100, 5'b00100, 5'b0, -1, 5'b0);

    // Reset in the middle of JUDGE.
    press(5'b00001);
    @(negedge clk); note_in_zone = 5'b00001; frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    #1 check_zero("async_reset");
    @(posedge clk); #1 check_zero("held_reset");
    @(negedge clk); reset = 1'b0; note_in_zone = '0;
    model_reset();
    frame(5'b0, 5'b00001, 5'b0, -1, 5'b0);

    // Simultaneous lanes 0, 2, 4.
    press(5'b10101);
    frame(5'b10101, 5'b10101, 5'b0, -1, 5'b0);
    chk("simul_score", score, 30);
    chk("simul_combo", combo, 3);

    // Long run through every multiplier step into the combo ceiling.
    for (int i = 0; i < 100; i++) begin
      press(5'b00001);
      frame(5'b00001, 5'b00001, 5'b0, -1, 5'b0);
    end
    chk("combo_cap", combo, 99);

    // note_passed coincident with a hit: combo cleared, points kept.
    press(5'b00001);
    frame(5'b00001, 5'b00001, 5'b0, 0, 5'b01000);
    chk("pass_hit_combo", combo, 0);
    chk("pass_hit_sat", s_score, 50);
    frame(5'b0, 5'b0, 5'b0, -1, 5'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule

// File: doc/hit_scorer.md
# hit_scorer

Upstream scoring stage for the rhythm-game display. It turns raw per-lane button presses into hit or miss judgements once per video frame, against which lanes have a note inside the hit zone. It tracks a combo count and multiplier and holds a saturating score. The 17-bit `score` output drives the score input of the screen generator's digit generators, replacing the constant score value used today. It also pulses `note_clear` back to the lane generators so that a hit note disappears.

## Interface
Parameters:
- `NUM_LANES`, 5, number of note lanes; bit 0 is the green lane, bit 4 is the white lane.
- `BASE_POINTS`, 10, points awarded per hit before the multiplier.
- `SCORE_MAX`, 99999, saturation ceiling for `score`, so that five display digits never overflow.
- `COMBO_MAX`, 99, saturation ceiling for `combo`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`, in, 1, system/pixel clock.
  - `reset`, in, 1, asynchronous, active-high.
- `frame_tick`, in, 1, one-cycle pulse once per frame at the start of vertical blanking.
- `button`, in, NUM_LANES, raw asynchronous push-buttons, active-high.
- `note_in_zone`, in, NUM_LANES, level signal from the lanes: a note currently overlaps hit-zone rows 426–470.
- `note_passed`, in, NUM_LANES, one-cycle pulse from a lane when a note leaves the bottom of the screen without being cleared.
- `note_clear`, out, NUM_LANES, one-cycle pulse telling a lane to remove its hit-zone note.
- `score`, out, 17, current score in binary, range 0..SCORE_MAX.
- `combo`, out, 7, consecutive hits, range 0..COMBO_MAX.
- `miss_flash`, out, 1, high for one full frame after any miss.

## Operation
- **Press capture:**
  - Each button passes through a 2-flop synchronizer and then a rising-edge detector.
  - An edge sets a sticky `pending[i]` bit. A held button produces only one press.
- **FSM states:** IDLE, JUDGE, DONE.
  - **IDLE:**
    - On `frame_tick`, copy `pending` to `snap`, copy `note_in_zone` to `zone_snap`, clear `pending`, set `lane_idx` = 0, and go to JUDGE.
    - An edge arriving in the same cycle as `frame_tick` goes into `pending` for the next frame, not into `snap`.
  - **JUDGE:** handles one lane per cycle, lane `lane_idx`, for `lane_idx` = 0..NUM_LANES−1.
    - If `snap[i]` = 0: no action.
    - If `snap[i]` = 1 and `zone_snap[i]` = 1 (hit):
      - `score` ← min(`score` + BASE_POINTS×mult, SCORE_MAX).
      - `combo` ← min(`combo`+1, COMBO_MAX).
      - `note_clear[i]` pulses in that cycle.
    - If `snap[i]` = 1 and `zone_snap[i]` = 0 (miss): `combo` ← 0 and a miss is flagged. `score` never decreases.
    - After the last lane, go to DONE.
  - **DONE:**
    - One cycle; `miss_flash` ← 1 if any miss was flagged this frame or since the last judgement, else 0.
    - Go to IDLE.
- **Multiplier:** uses `combo` before the increment.
  - combo 0–7 → ×1.
  - combo 8–15 → ×2.
  - combo 16–23 → ×3.
  - combo ≥ 24 → ×4.
- **Score arithmetic:**
  - Compute the sum at 18 bits and compare with SCORE_MAX before truncating to 17 bits.
  - BASE_POINTS×mult is at most 40.
- **`note_passed`:**
  - Any bit high in any state sets `combo` ← 0 and the miss flag.
  - If it coincides with a JUDGE hit increment, the reset wins; the score is still awarded.
- **`frame_tick` outside IDLE:** ignored. Presses keep accumulating in `pending`.

## Timing
- **Reset values:**
  - Outputs: `score` = 0, `combo` = 0, `note_clear` = 0, `miss_flash` = 0.
  - Internal: state = IDLE; `pending`, `snap`, `zone_snap`, synchronizers and edge registers all 0.
- **Button latency:** a press reaches `pending` 3 cycles after the button rises (2 synchronizer stages plus the edge register).
- **Judgement latency:**
  - `frame_tick` at cycle T → JUDGE of lane i at cycle T+1+i.
  - `score`, `combo` and `note_clear[i]` are registered and visible at T+2+i.
  - DONE at T+1+NUM_LANES. `miss_flash` updates at T+2+NUM_LANES and holds until the next DONE.
  - The whole sequence is far shorter than vertical blanking, so the displayed score is stable during active video.
- **Reset mid-JUDGE:** everything returns to reset values immediately. Partially judged presses are dropped.

## Structure
- **Shared package `game_pkg`:**
  - `NUM_LANES`, `SCORE_MAX`, `COMBO_MAX`, `BASE_POINTS`.
  - The FSM state enum `judge_state_t`.
  - A `combo_mult(combo)` function returning a 3-bit multiplier.
- **Sub-module `lane_press_detect`:**
  - Contains one lane's synchronizer, edge detector and sticky pending bit, with a clear input.
  - Instantiated NUM_LANES times with a generate loop.
- **Top level:** the FSM, score/combo datapath and miss flag stay in `hit_scorer`.

## Test plan
- **Basic hits:** after reset, press lane 0 with `note_in_zone` = 00001, then `frame_tick`, three frames in a row → `score` = 30, `combo` = 3, `note_clear[0]` pulses once per frame, 2 cycles after each tick.
- **Multiplier step:** from `combo` = 8 and `score` = 80, one hit → `score` = 100 (×2), `combo` = 9. From `combo` = 24, one hit → score +40.
- **Wrong press:** press lane 3 with `note_in_zone` = 0 at `combo` = 5 → `combo` = 0, score unchanged, `miss_flash` = 1 until the next DONE, no `note_clear`.
- **Simultaneous lanes:** press lanes 0, 2 and 4 in the same frame, all with notes in zone → `note_clear` pulses on bits 0, 2 and 4 at T+2, T+4 and T+6, `score` = 30, `combo` = 3.
- **Saturation:** set SCORE_MAX = 50 and run 6 single hits → `score` goes 10, 20, 30, 40, 50, 50. Then a `note_passed` pulse coincident with a hit → `combo` = 0 and the score is still capped.
- **Edge cases:**
  - A button held across 4 frames → only one judgement.
  - A press in the same cycle as `frame_tick` → judged next frame.
  - `reset` asserted at T+3 → all outputs 0 at the next edge.
